uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the UART transmit path (w_data / wr_uart / Tx_full) between N_REQ packet sources.
- Grants one requester at a time.
- Holds the grant until that requester's last byte is pushed into the Tx FIFO.
- Throttles all writes on Tx_full.
- Sits between internal byte producers (command responders, debug dumpers) and the UART top level.

---
 rtl/uart_tx_arbiter.sv | 150 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit FIFO write port among N_REQ byte producers.
// Optional idle-valid packet abort is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               Tx_full,
  output logic [7:0]         w_data,
  output logic               wr_uart,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               timeout_err
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IdxW:0]   NReqW   = (IdxW+1)'(N_REQ);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_REQ - 1);

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;

  logic              xfer;
  logic [IdxW-1:0]   g_idx;
  logic [IdxW-1:0]   nxt_ptr;
  logic              g_valid;
  logic              g_last;
  logic              arb_found;
  logic [IdxW-1:0]   arb_idx;
  logic [IdxW:0]     cand;
  logic              timeout_hit;

  // First valid requester searching upward from rr_ptr with wrap.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + i[IdxW:0];
      if (cand >= NReqW) begin
        cand = cand - NReqW;
      end
      if (!arb_found && req_valid[cand[IdxW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    g_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        g_idx = i[IdxW-1:0];
      end
    end
  end

  assign nxt_ptr   = (g_idx == LastIdx) ? '0 : g_idx + 1'b1;
  assign xfer      = (state_q == StXfer);
  assign g_valid   = req_valid[g_idx];
  assign g_last    = req_last[g_idx];
  assign busy      = xfer;
  assign grant     = grant_q;
  assign wr_uart   = xfer & g_valid & ~Tx_full;
  assign req_ready = (xfer && !Tx_full) ? grant_q : '0;
  assign w_data    = wr_uart ? req_data[{g_idx, 3'b000} +: 8] : 8'h00;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_err_q, timeout_err_d;

  // Tx_full stalls with valid held high never advance the counter.
  assign timeout_hit = xfer && !g_valid && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d         = cnt_q;
    timeout_err_d = timeout_hit;
    if (!xfer || wr_uart || timeout_hit) begin
      cnt_d = '0;
    end else if (!g_valid) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          state_d          = StXfer;
          grant_d          = '0;
          grant_d[arb_idx] = 1'b1;
        end
      end
      StXfer: begin
        if ((wr_uart && g_last) || timeout_hit) begin
          state_d  = StIdle;
          grant_d  = '0;
          rr_ptr_d = nxt_ptr;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (N_REQ=4, TIMEOUT_CYCLES=16).
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        tx_full = 1'b0;
  logic [7:0]  w_data;
  logic        wr_uart;
  logic [3:0]  grant;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int failures = 0;

  int len [4];
  int pos [4];
  int base [4];
  logic [3:0] hold;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .Tx_full    (tx_full),
    .w_data     (w_data),
    .wr_uart    (wr_uart),
    .grant      (grant),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  task automatic clear_pkts();
    for (int i = 0; i < 4; i++) begin
      len[i] = 0;
      pos[i] = 0;
      base[i] = 0;
    end
    hold = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = (pos[i] < len[i]) && !hold[i];
      req_data[i*8 +: 8] = 8'(base[i] + pos[i]);
      req_last[i] = (pos[i] == len[i] - 1);
    end
  endtask

  // Requester side of the handshake: advance on accepted bytes, then drive the next cycle.
  task automatic advance(input logic nxt_full);
    logic [3:0] acc;
    acc = req_ready & req_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) pos[i]++;
    end
    tx_full = nxt_full;
    drive();
  endtask

  task automatic test_reset();
    clear_pkts();
    for (int i = 0; i < 4; i++) begin
      len[i] = 1;
      base[i] = 8'hE0 + i;
    end
    drive();
    rst_n = 1'b0;
    #3;
    checks++;
    if (grant !== 4'b0000 || wr_uart !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs grant=%b wr=%b busy=%b want 0000/0/0", grant, wr_uart, busy);
    end
    checks++;
    if (req_ready !== 4'b0000 || w_data !== 8'h00 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready ready=%b w_data=%h terr=%b want 0000/00/0",
               req_ready, w_data, timeout_err);
    end
    clear_pkts();
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (grant !== 4'b0000 || wr_uart !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL idle c%0d grant=%b wr=%b busy=%b want 0000/0/0", c, grant, wr_uart, busy);
      end
      advance(1'b0);
    end
  endtask

  task automatic test_single_packet();
    logic       ew [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] ed [5] = '{8'h00, 8'h41, 8'h42, 8'h43, 8'h00};
    logic [3:0] eg [5] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h0};
    clear_pkts();
    len[2] = 3;
    base[2] = 8'h41;
    drive();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (wr_uart !== ew[c] || w_data !== ed[c]) begin
        failures++;
        $display("FAIL single c%0d wr=%b data=%h want %b/%h", c, wr_uart, w_data, ew[c], ed[c]);
      end
      checks++;
      if (grant !== eg[c] || busy !== (eg[c] != 4'h0)) begin
        failures++;
        $display("FAIL single_grant c%0d grant=%b busy=%b want %b", c, grant, busy, eg[c]);
      end
      advance(1'b0);
    end
  endtask

  // rr_ptr is 3 here: requester 3 must beat requester 1.
  task automatic test_rr_ptr();
    logic       ew [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] ed [5] = '{8'h00, 8'h53, 8'h00, 8'h51, 8'h00};
    logic [3:0] eg [5] = '{4'h0, 4'h8, 4'h0, 4'h2, 4'h0};
    clear_pkts();
    len[1] = 1;
    base[1] = 8'h51;
    len[3] = 1;
    base[3] = 8'h53;
    drive();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (wr_uart !== ew[c] || w_data !== ed[c] || grant !== eg[c]) begin
        failures++;
        $display("FAIL rr_ptr c%0d wr=%b data=%h grant=%b want %b/%h/%b",
                 c, wr_uart, w_data, grant, ew[c], ed[c], eg[c]);
      end
      advance(1'b0);
    end
  endtask

  task automatic test_reset_mid_packet();
    logic       ew [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] ed [8] = '{8'h00, 8'h61, 8'h62, 8'h63, 8'h64, 8'h00, 8'h73, 8'h00};
    logic [3:0] eg [8] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h8, 4'h0};
    clear_pkts();
    len[1] = 4;
    base[1] = 8'h61;
    drive();
    @(negedge clk);
    advance(1'b0);
    @(negedge clk);
    checks++;
    if (wr_uart !== 1'b1 || w_data !== 8'h61 || grant !== 4'h2) begin
      failures++;
      $display("FAIL pre_reset wr=%b data=%h grant=%b want 1/61/0010", wr_uart, w_data, grant);
    end
    advance(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== 4'h0 || wr_uart !== 1'b0 || busy !== 1'b0 || req_ready !== 4'h0) begin
      failures++;
      $display("FAIL async_reset grant=%b wr=%b busy=%b ready=%b want 0000/0/0/0000",
               grant, wr_uart, busy, req_ready);
    end
    clear_pkts();
    len[1] = 4;
    base[1] = 8'h61;
    len[3] = 1;
    base[3] = 8'h73;
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (wr_uart !== ew[c] || w_data !== ed[c] || grant !== eg[c]) begin
        failures++;
        $display("FAIL after_reset c%0d wr=%b data=%h grant=%b want %b/%h/%b",
                 c, wr_uart, w_data, grant, ew[c], ed[c], eg[c]);
      end
      advance(1'b0);
    end
  endtask

  task automatic test_round_robin();
    logic       ew [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] ed [10] = '{8'h00, 8'h10, 8'h11, 8'h00, 8'h20, 8'h21, 8'h00, 8'h30, 8'h31,
                            8'h00};
    logic [3:0] eg [10] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h8, 4'h8, 4'h0};
    int writes;
    writes = 0;
    clear_pkts();
    len[0] = 2;
    base[0] = 8'h10;
    len[1] = 2;
    base[1] = 8'h20;
    len[3] = 2;
    base[3] = 8'h30;
    drive();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (wr_uart === 1'b1) writes++;
      checks++;
      if (wr_uart !== ew[c] || w_data !== ed[c] || grant !== eg[c]) begin
        failures++;
        $display("FAIL round_robin c%0d wr=%b data=%h grant=%b want %b/%h/%b",
                 c, wr_uart, w_data, grant, ew[c], ed[c], eg[c]);
      end
      advance(1'b0);
    end
    checks++;
    if (writes != 6) begin
      failures++;
      $display("FAIL rr_write_count got %0d want 6", writes);
    end
  endtask

  task automatic test_tx_full();
    logic       ew [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] ed [9] = '{8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h81, 8'h82, 8'h00};
    logic [3:0] eg [9] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0};
    logic [3:0] er [9] = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0};
    clear_pkts();
    len[1] = 3;
    base[1] = 8'h80;
    tx_full = 1'b0;
    drive();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      checks++;
      if (wr_uart !== ew[c] || w_data !== ed[c] || grant !== eg[c]) begin
        failures++;
        $display("FAIL tx_full c%0d wr=%b data=%h grant=%b want %b/%h/%b",
                 c, wr_uart, w_data, grant, ew[c], ed[c], eg[c]);
      end
      checks++;
      if (req_ready !== er[c]) begin
        failures++;
        $display("FAIL tx_full_ready c%0d got %b want %b", c, req_ready, er[c]);
      end
      advance((c + 1 >= 2) && (c + 1 <= 5));
    end
  endtask

  // Requester 0 stalls after one byte while requester 1 waits.
  task automatic test_valid_drop();
    logic [3:0] eg;
    logic       ew;
    logic [7:0] ed;
    logic       et;
    clear_pkts();
    len[0] = 2;
    base[0] = 8'h90;
    len[1] = 1;
    base[1] = 8'hA1;
    drive();
    for (int c = 0; c < 21; c++) begin
      et = 1'b0;
      ew = (c == 1);
      ed = (c == 1) ? 8'h90 : 8'h00;
      eg = (c == 0) ? 4'h0 : 4'h1;
`ifdef UART_ARB_TIMEOUT_EN
      if (c == 18) begin
        eg = 4'h0;
        et = 1'b1;
      end else if (c == 19) begin
        eg = 4'h2;
        ew = 1'b1;
        ed = 8'hA1;
      end else if (c == 20) begin
        eg = 4'h0;
      end
`endif
      @(negedge clk);
      checks++;
      if (wr_uart !== ew || w_data !== ed || grant !== eg || timeout_err !== et) begin
        failures++;
        $display("FAIL valid_drop c%0d wr=%b data=%h grant=%b terr=%b want %b/%h/%b/%b",
                 c, wr_uart, w_data, grant, timeout_err, ew, ed, eg, et);
      end
      if (c == 1) hold[0] = 1'b1;
      advance(1'b0);
    end
  endtask

  initial begin
    clear_pkts();
    test_reset();
    test_single_packet();
    test_rr_ptr();
    test_reset_mid_packet();
    test_round_robin();
    test_tx_full();
    test_valid_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
